// File: rtl/mux32to1_pkg.sv
// Shared constants for the registered 32:1 data selector.
package mux32to1_pkg;

    localparam int N_IN          = 32;
    localparam int SEL_W         = 5;
    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mux32to1_comb.sv
// Purely combinational 32:1 selection of WIDTH-bit words.
module mux32to1_comb
    import mux32to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic [N_IN-1:0][WIDTH-1:0] d,
    input  logic [SEL_W-1:0]           sel,
    output logic [WIDTH-1:0]           y
);

    // A 5-bit code indexes exactly 32 entries, so every code has a defined result
    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/mux32to1.sv
// Registered 32:1 selector: Dout takes D[Sel] one clock after sampling.
module mux32to1
    import mux32to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [WIDTH-1:0] D8,
    input  logic [WIDTH-1:0] D9,
    input  logic [WIDTH-1:0] D10,
    input  logic [WIDTH-1:0] D11,
    input  logic [WIDTH-1:0] D12,
    input  logic [WIDTH-1:0] D13,
    input  logic [WIDTH-1:0] D14,
    input  logic [WIDTH-1:0] D15,
    input  logic [WIDTH-1:0] D16,
    input  logic [WIDTH-1:0] D17,
    input  logic [WIDTH-1:0] D18,
    input  logic [WIDTH-1:0] D19,
    input  logic [WIDTH-1:0] D20,
    input  logic [WIDTH-1:0] D21,
    input  logic [WIDTH-1:0] D22,
    input  logic [WIDTH-1:0] D23,
    input  logic [WIDTH-1:0] D24,
    input  logic [WIDTH-1:0] D25,
    input  logic [WIDTH-1:0] D26,
    input  logic [WIDTH-1:0] D27,
    input  logic [WIDTH-1:0] D28,
    input  logic [WIDTH-1:0] D29,
    input  logic [WIDTH-1:0] D30,
    input  logic [WIDTH-1:0] D31,
    input  logic [SEL_W-1:0] Sel,
    output logic [WIDTH-1:0] Dout
);

    logic [N_IN-1:0][WIDTH-1:0] d_bus;
    logic [WIDTH-1:0]           sel_data;

    // Packed bus with Dn at index n (D31 is the most significant element)
    assign d_bus = {D31, D30, D29, D28, D27, D26, D25, D24,
                    D23, D22, D21, D20, D19, D18, D17, D16,
                    D15, D14, D13, D12, D11, D10, D9,  D8,
                    D7,  D6,  D5,  D4,  D3,  D2,  D1,  D0};

    mux32to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .d   (d_bus),
        .sel (Sel),
        .y   (sel_data)
    );

    // Output register: cleared at once by reset, otherwise reloaded every cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Dout <= '0;
        end else begin
            Dout <= sel_data;
        end
    end

endmodule

// File: tb/tb_mux32to1.sv
// Directed-vector bench for the registered 32:1 selector.
module tb_mux32to1;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] d [32];
    logic [4:0]  Sel;
    logic [31:0] Dout;

    int checks   = 0;
    int failures = 0;

    mux32to1 #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .D0  (d[0]),  .D1  (d[1]),  .D2  (d[2]),  .D3  (d[3]),
        .D4  (d[4]),  .D5  (d[5]),  .D6  (d[6]),  .D7  (d[7]),
        .D8  (d[8]),  .D9  (d[9]),  .D10 (d[10]), .D11 (d[11]),
        .D12 (d[12]), .D13 (d[13]), .D14 (d[14]), .D15 (d[15]),
        .D16 (d[16]), .D17 (d[17]), .D18 (d[18]), .D19 (d[19]),
        .D20 (d[20]), .D21 (d[21]), .D22 (d[22]), .D23 (d[23]),
        .D24 (d[24]), .D25 (d[25]), .D26 (d[26]), .D27 (d[27]),
        .D28 (d[28]), .D29 (d[29]), .D30 (d[30]), .D31 (d[31]),
        .Sel   (Sel),
        .Dout  (Dout)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge and sample just after it
    task automatic edge_sample();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int sweep_sel [8] = '{0, 1, 2, 3, 4, 5, 30, 31};

        // Reset asserted before any clock edge, inputs Dn=n, Sel=7
        Rst_n = 1'b0;
        Sel   = 5'd7;
        for (int n = 0; n < 32; n++) d[n] = 32'(n);
        #2;
        chk("reset_no_edge", Dout, 32'h0);
        for (int k = 0; k < 3; k++) begin
            edge_sample();
            chk("reset_hold", Dout, 32'h0);
        end

        // Release reset; first edge loads D[Sel], then stepped sweep
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge Clk);
            Sel = 5'(sweep_sel[i]);
            edge_sample();
            chk($sformatf("sweep_sel%0d", sweep_sel[i]), Dout, 32'(sweep_sel[i]));
        end

        // Full sweep of all 32 codes with a tagged data pattern
        @(negedge Clk);
        for (int n = 0; n < 32; n++) d[n] = 32'hA5A50000 + 32'(n);
        for (int s = 0; s < 32; s++) begin
            if (s > 0) @(negedge Clk);
            Sel = 5'(s);
            edge_sample();
            chk($sformatf("full_sel%0d", s), Dout, 32'hA5A50000 + 32'(s));
        end

        // Select glitch between edges must not reach the output
        @(negedge Clk);
        Sel = 5'd3;
        edge_sample();
        chk("glitch_pre", Dout, 32'hA5A50003);
        #1 Sel = 5'd9;
        #1 chk("glitch_mid", Dout, 32'hA5A50003);
        Sel = 5'd3;
        #1 chk("glitch_back", Dout, 32'hA5A50003);
        edge_sample();
        chk("glitch_post", Dout, 32'hA5A50003);

        // Reset pulse mid-stream clears at once and drops the pending selection
        @(negedge Clk);
        Sel = 5'd10;
        edge_sample();
        chk("midrst_before", Dout, 32'hA5A5000A);
        #1 Rst_n = 1'b0;
        #1 chk("midrst_immediate", Dout, 32'h0);
        Sel = 5'd11;
        edge_sample();
        chk("midrst_held", Dout, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        Sel   = 5'd12;
        edge_sample();
        chk("midrst_release", Dout, 32'hA5A5000C);

        // Simultaneous change of Sel and the newly selected input
        @(negedge Clk);
        Sel   = 5'd20;
        d[20] = 32'hDEADBEEF;
        edge_sample();
        chk("simul_change", Dout, 32'hDEADBEEF);

        // Data-only changes with Sel fixed at 31
        @(negedge Clk);
        Sel   = 5'd31;
        d[31] = 32'd31;
        edge_sample();
        chk("data_d31_init", Dout, 32'd31);
        @(negedge Clk);
        d[31] = 32'hFFFFFFFF;
        #1 chk("data_d31_no_edge", Dout, 32'd31);
        edge_sample();
        chk("data_d31_ones", Dout, 32'hFFFFFFFF);
        @(negedge Clk);
        d[30] = 32'h12345678;
        edge_sample();
        chk("data_d30_ignored", Dout, 32'hFFFFFFFF);

        // Every unselected input toggled together: no effect on Dout
        @(negedge Clk);
        for (int n = 0; n < 31; n++) d[n] = ~d[n];
        edge_sample();
        chk("unselected_all", Dout, 32'hFFFFFFFF);

        // Low code with a fresh value, checks upper bits are not truncated
        @(negedge Clk);
        d[0] = 32'h80000001;
        Sel  = 5'd0;
        edge_sample();
        chk("sel0_fullwidth", Dout, 32'h80000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux32to1.md
MUX32TO1 -- requirements
Module: mux32to1

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every data input and of Dout.
REQ-002 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset.
REQ-004 D0..D31  input  WIDTH each  32 data inputs, where Dn is selected by Sel == n.
REQ-005 Sel  input  5  select code, unsigned 0..31.
REQ-006 Dout  output  WIDTH  registered selected data.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset (Rst_n).

Function
REQ-008 On each rising Clk edge with Rst_n high, Dout SHALL load D[Sel], where D[n] is port Dn.
REQ-009 Latency SHALL be exactly 1 cycle: values of Sel and Dn sampled at edge k appear on Dout after edge k.
REQ-010 All 32 Sel codes SHALL be valid, with no default/illegal case; Sel=0 selects D0 and Sel=31 selects D31.
REQ-011 Changes on Sel or Dn between clock edges SHALL NOT affect Dout until the next rising edge.
REQ-012 Unselected inputs SHALL have no effect on Dout.
REQ-013 Dout SHALL be a full-width copy of the selected input, with no truncation, extension or arithmetic.
REQ-014 Simultaneous change of Sel and the newly selected Dn before an edge SHALL yield the new Dn value after that edge.
REQ-015 The block SHALL have no enable and no handshake, and SHALL update Dout every cycle.
REQ-016 The block SHALL contain no FSM; the only state is the WIDTH-bit Dout register.

Reset
REQ-017 Rst_n low SHALL force Dout to 0 immediately, independent of Clk.
REQ-018 While Rst_n is low, Dout SHALL stay 0 regardless of Sel/Dn or clock edges.
REQ-019 After Rst_n rises, the first rising Clk edge SHALL load D[Sel] per REQ-008.
REQ-020 Reset asserted mid-operation SHALL discard the pending selection; there is no recovery state.

Structure
REQ-021 Package mux32to1_pkg SHALL hold the constants N_IN=32, SEL_W=5 and DEFAULT_WIDTH=32.
REQ-022 One sub-module, mux32to1_comb, SHALL implement the purely combinational 32:1 selection, parameterised by WIDTH.
REQ-023 mux32to1 SHALL instantiate mux32to1_comb and add the Dout register with asynchronous reset.
REQ-024 The implementation SHALL produce no latches, with a fully specified selection for every Sel code.

Verification
REQ-025 Reset: Rst_n=0 with Dn=n and Sel=7 -> Dout=0 without any clock edge; it stays 0 across 3 edges.
REQ-026 Sweep: Dn=n (n=0..31), Sel stepped 0,1,2,3,4,5,30,31 once per cycle -> Dout equals the previous cycle's Sel value (0,1,2,3,4,5,30,31).
REQ-027 Full sweep: Sel=0..31 with Dn=32'hA5A50000+n -> Dout=32'hA5A50000+Sel one cycle later, for all 32 codes.
REQ-028 Mid-cycle glitch: Sel=3 at the edge, Sel changed to 9 and back to 3 between edges -> Dout=D3 only, with no transient on Dout.
REQ-029 Reset mid-stream: during the sweep, pulse Rst_n low between edges -> Dout=0 at once; after release, the next edge gives D[Sel].
REQ-030 Data-only change: Sel=31 fixed, D31 changes 31 -> 32'hFFFFFFFF -> Dout=32'hFFFFFFFF after the next edge; changing D30 does not alter Dout.
